axis_to_axi_wr: RTL and testbench
=================================

AXIS_TO_AXI_WR -- requirements
Module: axis_to_axi_wr

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
  ADDR_W, 32, AXI address width.
  DATA_W, 64, stream/AXI data width; power of two, 32..512.
  ID_W, 4, AXI ID width.
  MAX_BURST, 16, maximum beats per AXI burst; 1..256.
  CNT_W, 20, width of the command beat count.
  AXI_ID, 0, constant AWID value.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
  aclk  in  1  single clock, all logic rising-edge.
  aresetn  in  1  reset, synchronous, active-low.
  cmd_valid/cmd_ready  in/out  1/1  command handshake.
  cmd_addr  in  ADDR_W  start byte address; low log2(DATA_W/8) bits ignored (treated as zero).
  cmd_beats  in  CNT_W  total beats; 0 is illegal and completes immediately with err.
  s_axis_tdata/tvalid/tready/tlast  in/in/out/in  DATA_W/1/1/1  stream input.
  m_axi_awid/awaddr/awlen/awsize/awburst/awcache/awprot/awvalid/awready  out x8, in  ID_W/ADDR_W/8/3/2/4/3/1/1  AXI4 write-address channel.
  m_axi_wdata/wstrb/wlast/wvalid/wready  out x4, in  DATA_W/DATA_W/8/1/1/1  write-data channel.
  m_axi_bid/bresp/bvalid/bready  in/in/in/out  ID_W/2/1/1  write-response channel.
  busy  out  1  command in progress.
  done  out  1  one-cycle pulse at command completion.
  err  out  1  valid with done: any non-OKAY bresp, tlast mismatch, or zero-length command.

Function
REQ-003 The FSM SHALL have states IDLE, ADDR, DATA, RESP.
REQ-004 In IDLE, cmd_ready SHALL be 1, and cmd_valid&cmd_ready SHALL latch address and count, clear the error accumulator, and go to ADDR.
REQ-005 On entry to ADDR, the burst length SHALL be min(remaining, MAX_BURST, (4096 - addr[11:0]) / (DATA_W/8)), so no burst crosses a 4 KB boundary.
REQ-006 In ADDR, awvalid SHALL be held with stable fields until awready.
  awlen = burst length - 1.
  awsize = log2(DATA_W/8).
  awburst = INCR (2'b01).
  awcache = 4'b0011.
  awprot = 0.
  awid = AXI_ID.
  Then go to DATA.
REQ-007 In DATA, the block SHALL connect the stream combinationally to W.
  wvalid = tvalid, tready = wready, wdata = tdata.
  wstrb all ones.
  wlast asserted on the final beat of the burst.
  tready SHALL be 0 in every other state.
REQ-008 A beat SHALL count only on wvalid&wready; after the last beat of the burst, the FSM SHALL go to RESP.
REQ-009 In RESP, bready SHALL be 1. On bvalid, the block SHALL:
  OR (bresp != OKAY) into the error accumulator;
  advance the address by burst_len*(DATA_W/8);
  subtract burst_len from the remaining count;
  go to ADDR if remaining > 0, else to IDLE with done=1.
REQ-010 Only one burst SHALL be outstanding; the next AW SHALL NOT be issued before the previous B is accepted.
REQ-011 tlast SHALL be checked on every accepted beat: tlast≠(final beat of command) SHALL set the error accumulator; data is still written with the commanded length.
REQ-012 cmd_beats=0 SHALL produce done=1, err=1 the cycle after acceptance, with no AXI traffic.
REQ-013 busy SHALL be 1 in every state except IDLE.
REQ-014 Address arithmetic SHALL wrap modulo 2^ADDR_W; the remaining count SHALL never underflow.
REQ-015 A bid mismatch SHALL be ignored.

Reset
REQ-016 While aresetn=0 at a clock edge, the FSM SHALL go to IDLE, and the following outputs SHALL be 0: awvalid, wvalid, bready, tready, done, err, busy.
REQ-017 Reset mid-burst SHALL abandon the command with no completion pulse; the AXI protocol consequences are the system's responsibility.

Structure
REQ-018 The FSM state enum and the AXI constants SHALL be in axi_pkg, and the block SHALL use the package burst_t, len_t, size_t, resp_t, cache_t and prot_t types.
  Constants: BURST_INCR=2'b01, RESP_OKAY=2'b00, BOUNDARY_4K=4096.
REQ-019 The burst-length calculation SHALL be in one combinational sub-module, axi_burst_calc.
  Inputs: addr, remaining, MAX_BURST, bytes-per-beat.
  Output: burst length.

Verification
REQ-020 DATA_W=64, MAX_BURST=16, addr 0x1000, 40 beats -> three bursts.
  AWADDR 0x1000/0x1080/0x1100, AWLEN 15/15/7; done=1, err=0 after third B.
REQ-021 addr 0x0FF0, 4 beats -> bursts 0x0FF0 len 1 (2 beats) and 0x1000 len 1 (2 beats); no 4 KB crossing.
REQ-022 Random tvalid/wready/awready/bvalid stalls with a 100-beat command -> stream data appears on W in order with no loss or duplication; wlast on each burst end.
REQ-023 Second burst returns bresp=SLVERR -> transfer continues; err=1 with done.
REQ-024 tlast asserted at beat 5 of 8 -> all 8 beats written; err=1.
REQ-025 aresetn=0 mid-DATA for one cycle -> all outputs 0 next cycle; a new command after reset completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared AXI4 write-side field types, protocol constants and the FSM state
// encoding used by axis_to_axi_wr and its burst-length helper.
// ---------------------------------------------------------------------------
package axi_pkg;

    typedef logic [1:0] burst_t;
    typedef logic [7:0] len_t;
    typedef logic [2:0] size_t;
    typedef logic [1:0] resp_t;
    typedef logic [3:0] cache_t;
    typedef logic [2:0] prot_t;

    localparam burst_t      BURST_INCR  = 2'b01;
    localparam resp_t       RESP_OKAY   = 2'b00;
    localparam int unsigned BOUNDARY_4K = 4096;

    // Normal non-cacheable bufferable memory, unprivileged/secure/data.
    localparam cache_t CACHE_BUF_MOD = 4'b0011;
    localparam prot_t  PROT_DEFAULT  = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } wr_state_e;

    // AxSIZE encoding for a beat of the given byte width (power of two).
    function automatic size_t size_of_bytes(input int unsigned bytes);
        return size_t'($clog2(bytes));
    endfunction

endpackage

// File: rtl/axi_burst_calc.sv
// ---------------------------------------------------------------------------
// axi_burst_calc
// Combinational length of the next INCR burst: the smallest of the beats
// still owed, MAX_BURST, and the beats left before the next 4 KB boundary.
//
// Ports
//   addr_i       low 12 bits of the beat-aligned burst start address
//   remaining_i  beats still to be written for the command (never 0 here)
//   burst_len_o  beats in the next burst (1..MAX_BURST)
// ---------------------------------------------------------------------------
module axi_burst_calc
    import axi_pkg::*;
#(
    parameter int CNT_W          = 20,
    parameter int MAX_BURST      = 16,
    parameter int BYTES_PER_BEAT = 8,
    parameter int LEN_W          = 5
) (
    input  logic [11:0]      addr_i,
    input  logic [CNT_W-1:0] remaining_i,
    output logic [LEN_W-1:0] burst_len_o
);

    localparam int BEAT_SHIFT = $clog2(BYTES_PER_BEAT);
    // Common compare width wide enough for the count and for 4096 bytes.
    localparam int CW = (CNT_W > 13) ? CNT_W : 13;

    logic [12:0]   bytes_to_4k;
    logic [CW-1:0] beats_to_4k;
    logic [CW-1:0] len_ext;

    always_comb begin
        bytes_to_4k = 13'(BOUNDARY_4K) - {1'b0, addr_i};
        beats_to_4k = CW'(bytes_to_4k >> BEAT_SHIFT);
        len_ext     = CW'(MAX_BURST);
        if (beats_to_4k < len_ext) len_ext = beats_to_4k;
        if (CW'(remaining_i) < len_ext) len_ext = CW'(remaining_i);
        burst_len_o = LEN_W'(len_ext);
    end

endmodule

// File: rtl/axis_to_axi_wr.sv
// ---------------------------------------------------------------------------
// axis_to_axi_wr
// Writes a commanded number of AXI-Stream beats to memory as a sequence of
// AXI4 INCR bursts, one burst outstanding at a time, never crossing 4 KB.
//
// Ports
//   aclk, aresetn            clock, synchronous active-low reset
//   cmd_*                    command: start byte address and beat count
//   s_axis_*                 stream input, passed straight through to W
//   m_axi_aw* / w* / b*      AXI4 write master (address, data, response)
//   busy                     a command is in progress
//   done                     one-cycle completion pulse
//   err                      with done: bad bresp, tlast mismatch or 0 beats
// ---------------------------------------------------------------------------
module axis_to_axi_wr
    import axi_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 64,
    parameter int              ID_W      = 4,
    parameter int              MAX_BURST = 16,
    parameter int              CNT_W     = 20,
    parameter logic [ID_W-1:0] AXI_ID    = '0
) (
    input  logic                aclk,
    input  logic                aresetn,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [CNT_W-1:0]    cmd_beats,

    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic                s_axis_tlast,

    output logic [ID_W-1:0]     m_axi_awid,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output len_t                m_axi_awlen,
    output size_t               m_axi_awsize,
    output burst_t              m_axi_awburst,
    output cache_t              m_axi_awcache,
    output prot_t               m_axi_awprot,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,

    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,

    input  logic [ID_W-1:0]     m_axi_bid,
    input  resp_t               m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,

    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int                BYTES      = DATA_W / 8;
    localparam int                OFF_W      = $clog2(BYTES);
    localparam int                LEN_W      = $clog2(MAX_BURST + 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);
    localparam size_t             AW_SIZE    = size_of_bytes(BYTES);

    wr_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic               err_acc_q, err_acc_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [LEN_W-1:0]   burst_len;
    logic               w_fire;
    logic               last_in_burst;
    logic               last_in_cmd;

    // Write responses are accepted regardless of ID; bid is deliberately unused.
    logic               unused_bid;
    assign unused_bid = ^m_axi_bid;

    // addr_q/rem_q only change in RESP, so the length stays stable across the
    // whole ADDR and DATA phase of a burst without a separate register.
    axi_burst_calc #(
        .CNT_W          (CNT_W),
        .MAX_BURST      (MAX_BURST),
        .BYTES_PER_BEAT (BYTES),
        .LEN_W          (LEN_W)
    ) u_burst_calc (
        .addr_i      (addr_q[11:0]),
        .remaining_i (rem_q),
        .burst_len_o (burst_len)
    );

    assign w_fire        = (state_q == DATA) && s_axis_tvalid && m_axi_wready;
    assign last_in_burst = (beat_q == burst_len - LEN_W'(1));
    // The final beat of the command is the final beat of the burst that
    // consumes everything still owed.
    assign last_in_cmd   = last_in_burst && (rem_q == CNT_W'(burst_len));

    // NOTE: every variable driven here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        beat_d    = beat_q;
        err_acc_d = err_acc_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr & ALIGN_MASK;
                    rem_d     = cmd_beats;
                    beat_d    = '0;
                    err_acc_d = 1'b0;
                    if (cmd_beats == '0) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end

            ADDR: begin
                beat_d = '0;
                if (m_axi_awready) state_d = DATA;
            end

            DATA: begin
                if (w_fire) begin
                    if (s_axis_tlast != last_in_cmd) err_acc_d = 1'b1;
                    if (last_in_burst) state_d = RESP;
                    else               beat_d  = beat_q + LEN_W'(1);
                end
            end

            RESP: begin
                if (m_axi_bvalid) begin
                    addr_d    = addr_q + (ADDR_W'(burst_len) << OFF_W);
                    rem_d     = rem_q - CNT_W'(burst_len);
                    err_acc_d = err_acc_q | (m_axi_bresp != RESP_OKAY);
                    if (rem_d == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        err_d   = err_acc_d;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_acc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_acc_q <= err_acc_d;
        end
    end

    // NOTE: address, count and beat index are always loaded before they are
    // read, so they carry no reset and stay off the reset tree.
    always_ff @(posedge aclk) begin
        addr_q <= addr_d;
        rem_q  <= rem_d;
        beat_q <= beat_d;
    end

    // cmd_ready is gated with reset so no command appears accepted while held.
    assign cmd_ready     = (state_q == IDLE) && aresetn;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign err           = err_q;

    assign m_axi_awid    = AXI_ID;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_t'(burst_len - LEN_W'(1));
    assign m_axi_awsize  = AW_SIZE;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awcache = CACHE_BUF_MOD;
    assign m_axi_awprot  = PROT_DEFAULT;
    assign m_axi_awvalid = (state_q == ADDR);

    assign m_axi_wdata   = s_axis_tdata;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = (state_q == DATA) && last_in_burst;
    assign m_axi_wvalid  = (state_q == DATA) && s_axis_tvalid;
    assign s_axis_tready = (state_q == DATA) && m_axi_wready;

    assign m_axi_bready  = (state_q == RESP);

endmodule

// File: tb/tb_axis_to_axi_wr.sv
// ---------------------------------------------------------------------------
// tb_axis_to_axi_wr
// Directed bench: a stream source, an AXI write slave with optional random
// stalls, and per-command checks of AW fields, W data order, wlast, done/err.
// ---------------------------------------------------------------------------
module tb_axis_to_axi_wr;
    import axi_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 64;
    localparam int ID_W      = 4;
    localparam int MAX_BURST = 16;
    localparam int CNT_W     = 20;

    logic                aclk;
    logic                aresetn;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [CNT_W-1:0]    cmd_beats;
    logic [DATA_W-1:0]   s_axis_tdata;
    logic                s_axis_tvalid;
    logic                s_axis_tready;
    logic                s_axis_tlast;
    logic [ID_W-1:0]     m_axi_awid;
    logic [ADDR_W-1:0]   m_axi_awaddr;
    len_t                m_axi_awlen;
    size_t               m_axi_awsize;
    burst_t              m_axi_awburst;
    cache_t              m_axi_awcache;
    prot_t               m_axi_awprot;
    logic                m_axi_awvalid;
    logic                m_axi_awready;
    logic [DATA_W-1:0]   m_axi_wdata;
    logic [DATA_W/8-1:0] m_axi_wstrb;
    logic                m_axi_wlast;
    logic                m_axi_wvalid;
    logic                m_axi_wready;
    logic [ID_W-1:0]     m_axi_bid;
    resp_t               m_axi_bresp;
    logic                m_axi_bvalid;
    logic                m_axi_bready;
    logic                busy;
    logic                done;
    logic                err;

    axis_to_axi_wr #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
        .MAX_BURST(MAX_BURST), .CNT_W(CNT_W), .AXI_ID('0)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache),
        .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .busy(busy), .done(done), .err(err)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- environment state ----------------
    bit   stall_en  = 1'b0;
    int   tlast_at  = 0;
    int   slverr_at = -1;
    int   src_idx   = 0;
    int   b_idx     = 0;
    int   pending_b = 0;
    int   done_cnt  = 0;
    bit   t_hold    = 1'b0;
    bit   b_hold    = 1'b0;

    logic [ADDR_W-1:0]   aw_addr_log[$];
    logic [7:0]          aw_len_log[$];
    logic [15:0]         aw_attr_log[$];
    logic [DATA_W-1:0]   w_data_log[$];
    logic                w_last_log[$];
    logic [DATA_W/8-1:0] w_strb_log[$];

    logic [ADDR_W-1:0]   exp_addr[$];
    int                  exp_len[$];

    function automatic logic [DATA_W-1:0] beat_data(input int i);
        return {32'hCAFE_0000, 32'(i)};
    endfunction

    function automatic bit rnd_ok();
        return !stall_en || ($urandom_range(0, 3) != 0);
    endfunction

    // Inputs change on the falling edge; handshakes are sampled 1 ns before
    // the rising edge, when everything feeding that edge is settled.
    always @(negedge aclk) begin
        s_axis_tvalid = t_hold ? 1'b1 : rnd_ok();
        s_axis_tdata  = beat_data(src_idx);
        s_axis_tlast  = (src_idx == tlast_at);
        m_axi_awready = rnd_ok();
        m_axi_wready  = rnd_ok();
        m_axi_bvalid  = (pending_b > 0) && (b_hold || rnd_ok());
        m_axi_bresp   = (b_idx == slverr_at) ? 2'b10 : RESP_OKAY;
        m_axi_bid     = 4'h5;
        #4;
        t_hold = s_axis_tvalid && !s_axis_tready;
        b_hold = m_axi_bvalid && !m_axi_bready;
        if (aresetn) begin
            if (m_axi_awvalid && m_axi_awready) begin
                aw_addr_log.push_back(m_axi_awaddr);
                aw_len_log.push_back(m_axi_awlen);
                aw_attr_log.push_back({m_axi_awsize, m_axi_awburst, m_axi_awcache,
                                       m_axi_awprot, m_axi_awid});
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_data_log.push_back(m_axi_wdata);
                w_last_log.push_back(m_axi_wlast);
                w_strb_log.push_back(m_axi_wstrb);
                if (m_axi_wlast) pending_b++;
            end
            if (s_axis_tvalid && s_axis_tready) src_idx++;
            if (m_axi_bvalid && m_axi_bready) begin
                pending_b--;
                b_idx++;
            end
            if (done) done_cnt++;
        end else begin
            pending_b = 0;
            src_idx   = 0;
            b_idx     = 0;
            t_hold    = 1'b0;
            b_hold    = 1'b0;
        end
    end

    // Independent burst plan: min(remaining, 16, beats to 4 KB), 8-byte beats.
    task automatic build_plan(input logic [ADDR_W-1:0] a_in, input int beats_in);
        logic [ADDR_W-1:0] a;
        int beats;
        int room;
        int n;
        a     = a_in & ~32'h7;
        beats = beats_in;
        exp_addr.delete();
        exp_len.delete();
        while (beats > 0) begin
            room = (4096 - int'(a[11:0])) / 8;
            n = beats;
            if (n > 16)   n = 16;
            if (n > room) n = room;
            exp_addr.push_back(a);
            exp_len.push_back(n);
            a     = a + 32'(n * 8);
            beats = beats - n;
        end
    endtask

    task automatic start_cmd(input logic [ADDR_W-1:0] a, input int beats, input int last_at);
        @(negedge aclk);
        #1;
        aw_addr_log.delete(); aw_len_log.delete(); aw_attr_log.delete();
        w_data_log.delete(); w_last_log.delete(); w_strb_log.delete();
        done_cnt  = 0;
        src_idx   = 0;
        b_idx     = 0;
        tlast_at  = last_at;
        cmd_addr  = a;
        cmd_beats = CNT_W'(beats);
        cmd_valid = 1'b1;
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge aclk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input logic exp_err);
        int c;
        c = 0;
        while (!done && c < budget) begin
            @(posedge aclk);
            #1;
            c++;
        end
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_err"}, err, exp_err);
        repeat (3) @(posedge aclk);
        #1;
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    task automatic check_stream(input string tag, input int nbeats);
        int k;
        int in_burst;
        check({tag, "_aw_count"}, aw_addr_log.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < aw_addr_log.size(); i++) begin
            check({tag, "_awaddr"}, aw_addr_log[i], exp_addr[i]);
            check({tag, "_awlen"}, aw_len_log[i], exp_len[i] - 1);
            check({tag, "_aw_attr"}, aw_attr_log[i],
                  {3'd3, 2'b01, 4'b0011, 3'b000, 4'h0});
        end
        check({tag, "_w_count"}, w_data_log.size(), nbeats);
        k = 0;
        in_burst = 0;
        for (int i = 0; i < nbeats && i < w_data_log.size() && k < exp_len.size(); i++) begin
            check({tag, "_wdata"}, w_data_log[i], beat_data(i));
            check({tag, "_wlast"}, w_last_log[i], in_burst == exp_len[k] - 1);
            check({tag, "_wstrb"}, w_strb_log[i], 8'hFF);
            if (in_burst == exp_len[k] - 1) begin
                k++;
                in_burst = 0;
            end else begin
                in_burst++;
            end
        end
    endtask

    initial begin
        int c;
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        aresetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_beats = '0;
        repeat (3) @(posedge aclk);
        #1;
        check("reset_outputs",
              {m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready, done, err, busy},
              7'b0);
        @(negedge aclk);
        aresetn = 1'b1;

        // 40 beats at 0x1000: 16 + 16 + 8.
        start_cmd(32'h1000, 40, 39);
        check("t1_busy", busy, 1);
        wait_done("t1", 2000, 1'b0);
        build_plan(32'h1000, 40);
        check_stream("t1", 40);
        check("t1_awaddr_2", aw_addr_log.size() > 2 ? aw_addr_log[2] : '1, 32'h1100);
        check("t1_awlen_2", aw_len_log.size() > 2 ? aw_len_log[2] : '1, 8'd7);

        // 0x0FF0, 4 beats: split at the 4 KB line into 2 + 2.
        start_cmd(32'h0FF0, 4, 3);
        wait_done("t2", 500, 1'b0);
        build_plan(32'h0FF0, 4);
        check_stream("t2", 4);
        check("t2_awaddr_1", aw_addr_log.size() > 1 ? aw_addr_log[1] : '1, 32'h1000);
        check("t2_awlen_1", aw_len_log.size() > 1 ? aw_len_log[1] : '1, 8'd1);

        // 100 beats with random stalls on every channel.
        stall_en = 1'b1;
        start_cmd(32'h2F00, 100, 99);
        wait_done("t3", 5000, 1'b0);
        build_plan(32'h2F00, 100);
        check_stream("t3", 100);
        stall_en = 1'b0;

        // SLVERR on the second burst: transfer still completes, err set.
        slverr_at = 1;
        start_cmd(32'h1000, 40, 39);
        wait_done("t4", 2000, 1'b1);
        build_plan(32'h1000, 40);
        check_stream("t4", 40);
        slverr_at = -1;

        // tlast on beat 5 of 8: all 8 beats still written, err set.
        start_cmd(32'h0, 8, 4);
        wait_done("t5", 500, 1'b1);
        build_plan(32'h0, 8);
        check_stream("t5", 8);

        // Zero-length command: immediate done+err, no AXI traffic.
        start_cmd(32'h500, 0, 0);
        check("t6_done", done, 1);
        check("t6_err", err, 1);
        check("t6_busy", busy, 0);
        repeat (5) @(posedge aclk);
        #1;
        check("t6_no_aw", aw_addr_log.size(), 0);
        check("t6_pulses", done_cnt, 1);

        // Reset for one cycle in the middle of DATA, then a fresh command.
        start_cmd(32'h1000, 40, 39);
        c = 0;
        while (w_data_log.size() < 5 && c < 200) begin
            @(posedge aclk);
            c++;
        end
        check("t7_reached_data", w_data_log.size() >= 5, 1);
        @(negedge aclk);
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        check("t7_reset_outputs",
              {m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready, done, err, busy},
              7'b0);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (5) @(posedge aclk);
        #1;
        check("t7_no_done", done_cnt, 0);
        check("t7_idle", busy, 0);
        start_cmd(32'h2005, 3, 2);
        wait_done("t7b", 500, 1'b0);
        build_plan(32'h2005, 3);
        check_stream("t7b", 3);
        check("t7b_awaddr", aw_addr_log.size() > 0 ? aw_addr_log[0] : '1, 32'h2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
